sb_tx_arbiter: RTL and testbench

//  Shares the sideband TX serializer among N_REQ message sources (LTSM, register access, credit return, ...).

---
 rtl/sb_pkg.sv | 6 +
 rtl/sb_rr_pick.sv | 31 +++
 rtl/sb_tx_arbiter.sv | 90 +++++++++
 tb/tb_sb_tx_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared sideband packet constants and arbiter state encoding
package sb_pkg;
  localparam int SB_PKT_W      = 64;
  localparam int SB_PKT_CYCLES = 96;
  typedef enum logic [0:0] {ARB_IDLE, ARB_SEND} sb_arb_state_t;
endpackage

// File: rtl/sb_rr_pick.sv
// sb_rr_pick: combinational round-robin winner search (SB_ARB_PRIO0_EN gives requester 0 strict priority)
module sb_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);
  localparam int IW = $clog2(N_REQ);
  logic [N_REQ-1:0] cand;
  // search from ptr upward; walking the offsets backwards lets the nearest hit win
  always_comb begin
`ifdef SB_ARB_PRIO0_EN
    cand = req[0] ? N_REQ'(1) : req;
`else
    cand = req;
`endif
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand[(int'(ptr) + k) % N_REQ]) begin
        idx = IW'((int'(ptr) + k) % N_REQ);
        any = 1'b1;
      end
    end
    gnt[idx] = any;
  end
endmodule

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter: credit-paced arbiter sharing the sideband TX serializer (build option SB_ARB_PRIO0_EN)
module sb_tx_arbiter
  import sb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TX_DEPTH    = 4,
  parameter int PKT_CYCLES  = SB_PKT_CYCLES,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                          clk_800MHz,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*SB_PKT_W-1:0]     req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [SB_PKT_W-1:0]           tx_data_o,
  output logic                          tx_valid_o,
  output logic                          tx_enable_o,
  input  logic                          tx_ack_i,
  output logic [$clog2(N_REQ)-1:0]      grant_id_o,
  output logic                          busy_o,
  output logic                          ack_timeout_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TX_DEPTH + 1);
  localparam int DW = $clog2(PKT_CYCLES);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  sb_arb_state_t state, state_n;
  logic [CW-1:0] credits;
  logic [DW-1:0] drain_ctr;
  logic [TW-1:0] to_ctr;
  logic [IW-1:0] rr_ptr, win;
  logic [N_REQ-1:0] gnt;
  logic any, accept, sending, ack_done, timeout, ret, full;
  sb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid_i),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (win),
    .any (any)
  );
  // next state and serializer handshake; a packet leaves on ack or after ACK_TIMEOUT silent cycles
  always_comb begin
    sending     = state == ARB_SEND;
    full        = credits == CW'(TX_DEPTH);
    accept      = !sending && credits != '0 && any;
    ack_done    = sending && tx_ack_i;
    timeout     = sending && !tx_ack_i && to_ctr == TW'(ACK_TIMEOUT - 1);
    ret         = !full && drain_ctr == DW'(PKT_CYCLES - 1);
    state_n     = accept ? ARB_SEND : (ack_done || timeout) ? ARB_IDLE : state;
    req_ready_o = accept ? gnt : '0;
    tx_valid_o  = sending;
    tx_enable_o = sending;
    busy_o      = sending;
  end
  // state register
  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_n;
  end
  // packet latch, grant bookkeeping and ack watchdog
  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      tx_data_o     <= '0;
      grant_id_o    <= '0;
      rr_ptr        <= '0;
      to_ctr        <= '0;
      ack_timeout_o <= 1'b0;
    end else begin
      if (accept) begin
        tx_data_o  <= req_data_i[SB_PKT_W*int'(win) +: SB_PKT_W];
        grant_id_o <= win;
      end
      to_ctr <= sending ? to_ctr + TW'(1) : '0;
      if (ack_done || timeout)
        rr_ptr <= (grant_id_o == IW'(N_REQ - 1)) ? '0 : grant_id_o + IW'(1);
      if (timeout) ack_timeout_o <= 1'b1;
    end
  end
  // credit model of the serializer buffer: one credit drains every PKT_CYCLES while not full
  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      credits   <= CW'(TX_DEPTH);
      drain_ctr <= '0;
    end else begin
      if (ret && !ack_done)                         credits <= credits + CW'(1);
      else if (ack_done && !ret && credits != '0)   credits <= credits - CW'(1);
      drain_ctr <= (full || ret) ? '0 : drain_ctr + DW'(1);
    end
  end
endmodule

// File: tb/tb_sb_tx_arbiter.sv
// tb_sb_tx_arbiter: directed and randomized bench against a cycle-level reference model
module tb_sb_tx_arbiter;
  localparam int N = 4, DEPTH = 4, PKT = 96, TMO = 16;
  logic clk_800MHz = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N*64-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic [63:0] tx_data;
  logic tx_valid, tx_enable, busy, ack_timeout;
  logic tx_ack = 1'b0;
  logic [1:0] grant_id;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit chk_en = 0;
  int m_cred, m_drain, m_ptr, m_gid, m_sent, m_win;
  bit m_busy, m_tmo, m_acc, m_ack, m_exp, m_ret;
  logic [63:0] m_data;
  logic [N-1:0] m_rdy;

  sb_tx_arbiter dut (
    .clk_800MHz    (clk_800MHz),
    .reset         (reset),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
    .req_ready_o   (req_ready),
    .tx_data_o     (tx_data),
    .tx_valid_o    (tx_valid),
    .tx_enable_o   (tx_enable),
    .tx_ack_i      (tx_ack),
    .grant_id_o    (grant_id),
    .busy_o        (busy),
    .ack_timeout_o (ack_timeout)
  );

  always #5 clk_800MHz = ~clk_800MHz;
  always @(posedge clk_800MHz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [N-1:0] v, int p);
`ifdef SB_ARB_PRIO0_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int clampc(int c);
    return c > DEPTH ? DEPTH : (c < 0 ? 0 : c);
  endfunction

  always_comb begin
    m_win = pick(req_valid, m_ptr);
    m_acc = !m_busy && m_cred > 0 && m_win >= 0;
    m_ack = m_busy && tx_ack;
    m_exp = m_busy && !tx_ack && m_sent == TMO;
    m_ret = m_cred < DEPTH && m_drain == PKT - 1;
    m_rdy = '0;
    if (m_acc) m_rdy[m_win] = 1'b1;
  end

  always @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_cred <= DEPTH; m_drain <= 0; m_ptr <= 0;
      m_gid <= 0; m_data <= '0; m_tmo <= 0; m_sent <= 0;
    end else begin
      m_cred  <= clampc(m_cred + int'(m_ret) - int'(m_ack));
      m_drain <= (m_cred == DEPTH || m_ret) ? 0 : m_drain + 1;
      if (m_acc) begin
        m_busy <= 1; m_sent <= 1; m_gid <= m_win; m_data <= req_data[64*m_win +: 64];
      end else if (m_busy) begin
        if (m_ack || m_exp) begin
          m_busy <= 0; m_ptr <= (m_gid + 1) % N;
          if (m_exp) m_tmo <= 1;
        end else m_sent <= m_sent + 1;
      end
    end
  end

  always @(negedge clk_800MHz) begin
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(m_rdy));
      check("tx_valid", 64'(tx_valid), 64'(m_busy));
      check("tx_enable", 64'(tx_enable), 64'(m_busy));
      check("busy", 64'(busy), 64'(m_busy));
      check("tx_data", tx_data, m_data);
      check("grant_id", 64'(grant_id), 64'(m_gid));
      check("ack_timeout", 64'(ack_timeout), 64'(m_tmo));
    end
  end

  task automatic tick();
    @(posedge clk_800MHz);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    tx_ack = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_pkt(input int dly, output int gid, output logic [63:0] dat, output int rc);
    int n = 0;
    do begin tick(); n++; end while (!tx_valid && n < 300);
    gid = -1; dat = '0; rc = cyc;
    if (!tx_valid) begin
      check("tx_valid_wait", 64'(tx_valid), 64'(1));
      return;
    end
    gid = int'(grant_id);
    dat = tx_data;
    repeat (dly) tick();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  initial begin
    int gid, rc, n;
    int r[5];
    logic [63:0] dat;
    logic [63:0] d[N];
    logic [N-1:0] rdy;
    int exp_g[7];
    int pct;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk_en = 1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_tx_valid", 64'(tx_valid), 64'(0));
    for (int i = 0; i < N; i++) begin
      d[i] = {$urandom, $urandom};
      req_data[64*i +: 64] = d[i];
    end
    // T1: asynchronous reset in the middle of SEND
    req_valid = 4'b0100;
    n = 0;
    do begin tick(); n++; end while (!tx_valid && n < 50);
    check("t1_send", 64'(tx_valid), 64'(1));
    check("t1_data", tx_data, d[2]);
    #2;
    reset = 1'b1;
    req_valid = '0;
    #1;
    check("t1_tx_valid", 64'(tx_valid), 64'(0));
    check("t1_tx_enable", 64'(tx_enable), 64'(0));
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_tx_data", tx_data, 64'(0));
    check("t1_grant", 64'(grant_id), 64'(0));
    check("t1_ready", 64'(req_ready), 64'(0));
    tick();
    reset = 1'b0;
    tick();
    check("t1_busy_after", 64'(busy), 64'(0));
    // T2: all requesters held, ack three cycles after each tx_valid
    do_reset();
`ifdef SB_ARB_PRIO0_EN
    exp_g = '{0, 0, 0, 0, 1, 2, 3};
    req_valid = 4'hF;
    for (int g = 0; g < 7; g++) begin
      if (g == 4) req_valid[0] = 1'b0;
      send_pkt(3, gid, dat, rc);
      check($sformatf("t2_grant%0d", g), 64'(gid), 64'(exp_g[g]));
    end
`else
    exp_g = '{0, 1, 2, 3, 0, 0, 0};
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      send_pkt(3, gid, dat, rc);
      check($sformatf("t2_grant%0d", g), 64'(gid), 64'(exp_g[g]));
    end
`endif
    // T3: five back-to-back packets from requester 1 against four credits
    do_reset();
    req_valid = 4'b0010;
    for (int p = 0; p < 5; p++) begin
      send_pkt(0, gid, dat, rc);
      r[p] = rc;
      check($sformatf("t3_grant%0d", p), 64'(gid), 64'(1));
    end
    check("t3_fourth_spacing", 64'(r[3] - r[0]), 64'(6));
    check("t3_fifth_wait", 64'(r[4] - r[0]), 64'(98));
    // T4: ack withheld -> abort after the timeout, next requester served
    do_reset();
    req_valid = 4'b0110;
    n = 0;
    do begin tick(); n++; end while (!tx_valid && n < 50);
    check("t4_first_grant", 64'(grant_id), 64'(1));
    n = 0;
    while (tx_valid && n < 40) begin n++; tick(); end
    check("t4_valid_cycles", 64'(n), 64'(TMO));
    check("t4_timeout_flag", 64'(ack_timeout), 64'(1));
    send_pkt(2, gid, dat, rc);
    check("t4_next_grant", 64'(gid), 64'(2));
    tick();
    check("t4_flag_sticky", 64'(ack_timeout), 64'(1));
    // T5: pointer wrap from 3 back to 0 with the right payloads
    do_reset();
    req_valid = 4'b1000;
    send_pkt(1, gid, dat, rc);
    check("t5_grant3", 64'(gid), 64'(3));
    check("t5_data3", dat, d[3]);
    req_valid = 4'b0011;
    send_pkt(1, gid, dat, rc);
    check("t5_grant0", 64'(gid), 64'(0));
    check("t5_data0", dat, d[0]);
    // T6: ack and credit return on the same edge at one credit
    do_reset();
    req_valid = 4'b0010;
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, gid, dat, rc);
      if (p == 0) r[0] = rc;
    end
    req_valid = '0;
    n = 0;
    while (cyc < r[0] + 95 && n < 200) begin tick(); n++; end
    req_valid = 4'b0010;
    send_pkt(0, gid, dat, rc);
    check("t6_sync_accept", 64'(rc - r[0]), 64'(96));
    send_pkt(0, gid, dat, rc);
    check("t6_credit_kept", 64'(rc - r[0]), 64'(98));
    n = 0;
    repeat (30) begin tick(); if (tx_valid) n++; end
    check("t6_stall", 64'(n), 64'(0));
    // randomized traffic with varying ack behaviour
    do_reset();
    rdy = '0;
    for (int b = 0; b < 8; b++) begin
      pct = (b == 2 || b == 5) ? 0 : int'($urandom_range(10, 100));
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < N; i++) begin
          if (req_valid[i] && rdy[i]) begin
            req_valid[i] = 1'($urandom_range(0, 1));
            req_data[64*i +: 64] = {$urandom, $urandom};
          end else if (!req_valid[i]) begin
            req_valid[i] = ($urandom_range(0, 3) == 0);
            req_data[64*i +: 64] = {$urandom, $urandom};
          end else if ($urandom_range(0, 63) == 0) req_valid[i] = 1'b0;
        end
        tx_ack = tx_valid && ($urandom_range(1, 100) <= pct);
        #1;
        rdy = req_ready;
        tick();
      end
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
